// File: rtl/icache_tag_req_arb_pkg.sv
// Shared types for the icache tag request arbiter: request payload, MSHR index,
// arbitration source encoding and the registered output-stage record.
package icache_tag_req_arb_pkg;

   localparam int ADDR_TAG_W             = 20;
   localparam int ADDR_INDEX_W           = 6;
   localparam int ADDR_OFFSET_W          = 6;
   localparam int MSHR_ENTRY_INDEX_WIDTH = 3;
   localparam int DBG_AGE_W              = 8;

   localparam logic [1:0] UPSTREAM_OPCODE   = 2'd0;
   localparam logic [1:0] DOWNSTREAM_OPCODE = 2'd1;
   localparam logic [1:0] PREFETCH_OPCODE   = 2'd2;

   typedef struct packed {
      logic [ADDR_TAG_W-1:0]    tag;
      logic [ADDR_INDEX_W-1:0]  index;
      logic [ADDR_OFFSET_W-1:0] offset;
   } pc_addr_t;

   typedef struct packed {
      logic [1:0] opcode;
      pc_addr_t   addr;
   } pc_req_t;

   typedef logic [MSHR_ENTRY_INDEX_WIDTH-1:0]  mshr_idx_t;
   typedef logic [ADDR_TAG_W+ADDR_INDEX_W-1:0] line_t;

   typedef enum logic [1:0] {
      ARB_SRC_NONE = 2'd0,
      ARB_SRC_SNP  = 2'd1,
      ARB_SRC_UP   = 2'd2,
      ARB_SRC_PF   = 2'd3
   } arb_src_e;

   typedef struct packed {
      pc_req_t   pld;
      mshr_idx_t index;
      logic      is_pf;
   } tag_arb_out_t;

   // Cache line identity ignores the byte offset.
   function automatic line_t req_line(pc_req_t r);
      return {r.addr.tag, r.addr.index};
   endfunction

endpackage

// File: rtl/icache_tag_req_arb_if.sv
// Bundle of the three request ports, the tag request port and debug taps.
interface icache_tag_req_arb_if;
   import icache_tag_req_arb_pkg::*;

   // Every *_vld/*_rdy pair transfers exactly when vld & rdy are both high at a
   // rising clock edge; a source may not depend on rdy to raise vld.
   logic      snp_req_vld;
   logic      snp_req_rdy;
   pc_req_t   snp_req_pld;

   logic      up_req_vld;
   logic      up_req_rdy;
   pc_req_t   up_req_pld;
   mshr_idx_t up_req_index;

   logic      pf_req_vld;
   logic      pf_req_rdy;
   pc_req_t   pf_req_pld;
   mshr_idx_t pf_req_index;

   logic      flush;

   logic      tag_req_vld;
   logic      tag_req_rdy;
   pc_req_t   tag_req_pld;
   mshr_idx_t tag_req_index;

   logic      pf_drop;
   logic      pf_promoted;

   arb_src_e              dbg_arb_src;
   logic [DBG_AGE_W-1:0]  dbg_pf_age;
   logic                  dbg_last_up_vld;

   modport slave (
      input  snp_req_vld, snp_req_pld,
      input  up_req_vld, up_req_pld, up_req_index,
      input  pf_req_vld, pf_req_pld, pf_req_index,
      input  flush, tag_req_rdy,
      output snp_req_rdy, up_req_rdy, pf_req_rdy,
      output tag_req_vld, tag_req_pld, tag_req_index,
      output pf_drop, pf_promoted,
      output dbg_arb_src, dbg_pf_age, dbg_last_up_vld
   );

   modport master (
      output snp_req_vld, snp_req_pld,
      output up_req_vld, up_req_pld, up_req_index,
      output pf_req_vld, pf_req_pld, pf_req_index,
      output flush, tag_req_rdy,
      input  snp_req_rdy, up_req_rdy, pf_req_rdy,
      input  tag_req_vld, tag_req_pld, tag_req_index,
      input  pf_drop, pf_promoted,
      input  dbg_arb_src, dbg_pf_age, dbg_last_up_vld
   );

endinterface

// File: rtl/icache_arb_age_cnt.sv
// Saturating wait counter for the prefetch requester; sat flags promotion.
module icache_arb_age_cnt #(
   parameter int LIMIT = 8,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         sat
);

   localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != LIMIT_V)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign sat = (cnt_q == LIMIT_V);

endmodule

// File: rtl/icache_tag_req_arb.sv
// Snoop / fetch / prefetch arbiter feeding the tag array through a one-entry
// registered stage, with prefetch starvation promotion and duplicate-line drop.
module icache_tag_req_arb
   import icache_tag_req_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 8,
   parameter int AGE_W        = $clog2(STARVE_LIMIT + 1)
) (
   input logic                 clk,
   input logic                 rst_n,
   icache_tag_req_arb_if.slave bus
);

   logic         out_vld_q;
   logic         out_vld_d;
   tag_arb_out_t out_q;
   tag_arb_out_t out_d;
   line_t        last_up_line_q;
   line_t        last_up_line_d;
   logic         last_up_vld_q;
   logic         last_up_vld_d;

   logic         load_en;
   arb_src_e     src;
   logic         pf_dup;
   logic         load;
   logic         age_inc;
   logic         age_clr;
   logic         age_sat;
   logic [AGE_W-1:0] age_cnt;

   // Grant decision uses only valids, flush and registered state so that
   // the ready outputs never depend on request payloads.
   always_comb begin
      load_en = ~out_vld_q | bus.tag_req_rdy;
      src     = ARB_SRC_NONE;
      if (load_en) begin
         if (bus.snp_req_vld) begin
            src = ARB_SRC_SNP;
         end else if (bus.pf_req_vld && age_sat && !bus.flush) begin
            src = ARB_SRC_PF;
         end else if (bus.up_req_vld) begin
            src = ARB_SRC_UP;
         end else if (bus.pf_req_vld && !bus.flush) begin
            src = ARB_SRC_PF;
         end
      end
   end

   assign pf_dup = (src == ARB_SRC_PF) && last_up_vld_q &&
                   (req_line(bus.pf_req_pld) == last_up_line_q);
   assign load   = (src != ARB_SRC_NONE) && !pf_dup;

   always_comb begin
      out_d     = out_q;
      out_vld_d = out_vld_q;
      if (load) begin
         out_vld_d = 1'b1;
         unique case (src)
            ARB_SRC_SNP: begin
               out_d.pld   = bus.snp_req_pld;
               out_d.index = '0;
               out_d.is_pf = 1'b0;
            end
            ARB_SRC_UP: begin
               out_d.pld   = bus.up_req_pld;
               out_d.index = bus.up_req_index;
               out_d.is_pf = 1'b0;
            end
            default: begin
               out_d.pld   = bus.pf_req_pld;
               out_d.index = bus.pf_req_index;
               out_d.is_pf = 1'b1;
            end
         endcase
      end else if (load_en || (bus.flush && out_q.is_pf)) begin
         // Either the held entry was consumed, or a flush kills a held prefetch.
         out_vld_d = 1'b0;
      end
   end

   always_comb begin
      last_up_line_d = last_up_line_q;
      last_up_vld_d  = last_up_vld_q;
      if (src == ARB_SRC_UP) begin
         last_up_line_d = req_line(bus.up_req_pld);
         last_up_vld_d  = 1'b1;
      end else if (bus.flush) begin
         last_up_vld_d  = 1'b0;
      end
   end

   assign age_inc = bus.pf_req_vld && load_en && (src != ARB_SRC_PF);
   assign age_clr = (src == ARB_SRC_PF) || bus.flush || !bus.pf_req_vld;

   icache_arb_age_cnt #(
      .LIMIT (STARVE_LIMIT),
      .W     (AGE_W)
   ) u_age_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (age_inc),
      .clr   (age_clr),
      .cnt   (age_cnt),
      .sat   (age_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q     <= 1'b0;
         last_up_vld_q <= 1'b0;
      end else begin
         out_vld_q     <= out_vld_d;
         last_up_vld_q <= last_up_vld_d;
      end
   end

   // Payload registers are qualified by their valid bits and carry no reset.
   always_ff @(posedge clk) begin
      out_q          <= out_d;
      last_up_line_q <= last_up_line_d;
   end

   assign bus.snp_req_rdy     = (src == ARB_SRC_SNP);
   assign bus.up_req_rdy      = (src == ARB_SRC_UP);
   assign bus.pf_req_rdy      = (src == ARB_SRC_PF);
   assign bus.tag_req_vld     = out_vld_q;
   assign bus.tag_req_pld     = out_q.pld;
   assign bus.tag_req_index   = out_q.index;
   assign bus.pf_drop         = pf_dup;
   assign bus.pf_promoted     = age_sat;
   assign bus.dbg_arb_src     = src;
   assign bus.dbg_pf_age      = DBG_AGE_W'(age_cnt);
   assign bus.dbg_last_up_vld = last_up_vld_q;

endmodule

// File: tb/tb_icache_tag_req_arb.sv
// Bench for icache_tag_req_arb: directed table, starvation/backpressure/reset
// sequences, then randomized traffic against a cycle-level reference model.
module tb_icache_tag_req_arb;
   import icache_tag_req_arb_pkg::*;

   localparam int LIMIT = 8;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   icache_tag_req_arb_if bus();

   icache_tag_req_arb #(.STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- stimulus records ----------------
   typedef struct {
      logic       snp, up, pf, fl, trdy;
      logic [7:0] snp_tag, up_tag, pf_tag;
      logic [5:0] up_line, pf_line, off;
      logic [2:0] up_mi, pf_mi;
   } stim_t;

   typedef struct {
      stim_t      s;
      logic [2:0] e_rdy;   // {snp, up, pf}
      logic       e_drop;
      logic       e_tvld;
      logic [2:0] e_tidx;
      logic       e_luv;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic pc_req_t mk(input logic [1:0] op, input logic [7:0] tag,
                                  input logic [5:0] line, input logic [5:0] off);
      pc_req_t r;
      r.opcode      = op;
      r.addr.tag    = {12'h000, tag};
      r.addr.index  = line;
      r.addr.offset = off;
      return r;
   endfunction

   function automatic stim_t st(input logic snp, up, pf, fl, trdy,
                                input logic [7:0] ut, input logic [5:0] ul, input logic [2:0] um,
                                input logic [7:0] pt, input logic [5:0] pl, input logic [2:0] pm);
      stim_t s;
      s.snp = snp; s.up = up; s.pf = pf; s.fl = fl; s.trdy = trdy;
      s.snp_tag = 8'hAA; s.off = 6'd0;
      s.up_tag = ut; s.up_line = ul; s.up_mi = um;
      s.pf_tag = pt; s.pf_line = pl; s.pf_mi = pm;
      return s;
   endfunction

   function automatic vec_t vrow(input stim_t s, input logic [2:0] e_rdy, input logic e_drop,
                                 input logic e_tvld, input logic [2:0] e_tidx, input logic e_luv);
      vec_t v;
      v.s = s; v.e_rdy = e_rdy; v.e_drop = e_drop;
      v.e_tvld = e_tvld; v.e_tidx = e_tidx; v.e_luv = e_luv;
      return v;
   endfunction

   // ---------------- reference model ----------------
   // Source ranks: 0 none, 1 snoop, 2 upstream, 3 prefetch.
   bit         m_out_vld;
   pc_req_t    m_out_pld;
   logic [2:0] m_out_idx;
   bit         m_out_pf;
   int         m_age;
   logic [13:0] m_last_line;
   bit         m_last_vld;
   int         m_src;
   bit         m_drop;
   bit         m_free;

   task automatic model_reset();
      m_out_vld = 0; m_out_pf = 0; m_age = 0; m_last_vld = 0;
   endtask

   task automatic model_eval(input stim_t s);
      m_free = !m_out_vld || s.trdy;
      m_src  = 0;
      if (m_free) begin
         if (s.snp)                                 m_src = 1;
         else if (s.pf && !s.fl && m_age == LIMIT) m_src = 3;
         else if (s.up)                            m_src = 2;
         else if (s.pf && !s.fl)                   m_src = 3;
      end
      m_drop = (m_src == 3) && m_last_vld && ({s.pf_tag, s.pf_line} == m_last_line);
   endtask

   task automatic model_check();
      chk("snp_rdy", 64'(bus.snp_req_rdy), 64'(m_src == 1));
      chk("up_rdy",  64'(bus.up_req_rdy),  64'(m_src == 2));
      chk("pf_rdy",  64'(bus.pf_req_rdy),  64'(m_src == 3));
      chk("pf_drop", 64'(bus.pf_drop),     64'(m_drop));
      chk("tag_vld", 64'(bus.tag_req_vld), 64'(m_out_vld));
      if (m_out_vld) begin
         chk("tag_pld", 64'(bus.tag_req_pld),   64'(m_out_pld));
         chk("tag_idx", 64'(bus.tag_req_index), 64'(m_out_idx));
      end
      chk("promoted", 64'(bus.pf_promoted), 64'(m_age == LIMIT));
      chk("pf_age",   64'(bus.dbg_pf_age),  64'(m_age));
      chk("last_up_vld", 64'(bus.dbg_last_up_vld), 64'(m_last_vld));
   endtask

   task automatic model_commit(input stim_t s);
      if (m_src == 3 || s.fl || !s.pf) m_age = 0;
      else if (m_free)                 m_age = (m_age + 1 > LIMIT) ? LIMIT : m_age + 1;

      if (m_src == 2) begin
         m_last_line = {s.up_tag, s.up_line};
         m_last_vld  = 1;
      end else if (s.fl) begin
         m_last_vld  = 0;
      end

      if (m_src != 0 && !m_drop) begin
         m_out_vld = 1;
         m_out_pf  = (m_src == 3);
         case (m_src)
            1:       begin m_out_pld = mk(DOWNSTREAM_OPCODE, s.snp_tag, 6'd0, s.off); m_out_idx = 3'd0; end
            2:       begin m_out_pld = mk(UPSTREAM_OPCODE, s.up_tag, s.up_line, s.off); m_out_idx = s.up_mi; end
            default: begin m_out_pld = mk(PREFETCH_OPCODE, s.pf_tag, s.pf_line, s.off); m_out_idx = s.pf_mi; end
         endcase
      end else if (m_free || (s.fl && m_out_pf)) begin
         m_out_vld = 0;
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input stim_t s);
      bus.snp_req_vld  = s.snp;
      bus.snp_req_pld  = mk(DOWNSTREAM_OPCODE, s.snp_tag, 6'd0, s.off);
      bus.up_req_vld   = s.up;
      bus.up_req_pld   = mk(UPSTREAM_OPCODE, s.up_tag, s.up_line, s.off);
      bus.up_req_index = s.up_mi;
      bus.pf_req_vld   = s.pf;
      bus.pf_req_pld   = mk(PREFETCH_OPCODE, s.pf_tag, s.pf_line, s.off);
      bus.pf_req_index = s.pf_mi;
      bus.flush        = s.fl;
      bus.tag_req_rdy  = s.trdy;
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic step(input stim_t s, input bit use_model);
      @(negedge clk);
      drive(s);
      #1;
      model_eval(s);
      if (use_model) model_check();
      model_commit(s);
   endtask

   // ---------------- test ----------------
   vec_t    tbl[17];
   stim_t   idle, rs;
   int      up_wins;
   bit      heavy;
   pc_req_t bp_pld;

   initial begin
      idle = st(0,0,0,0,1, 8'h0,6'd0,3'd0, 8'h0,6'd0,3'd0);
      tbl[0]  = vrow(idle,                                                   3'b000,0,0,3'd0,0);
      tbl[1]  = vrow(st(0,1,0,0,1, 8'h12,6'd1,3'd3, 8'h0,6'd0,3'd0),         3'b010,0,0,3'd0,0);
      tbl[2]  = vrow(idle,                                                   3'b000,0,1,3'd3,1);
      tbl[3]  = vrow(st(1,1,0,0,1, 8'h13,6'd2,3'd5, 8'h0,6'd0,3'd0),         3'b100,0,0,3'd0,1);
      tbl[4]  = vrow(st(0,1,0,0,1, 8'h13,6'd2,3'd5, 8'h0,6'd0,3'd0),         3'b010,0,1,3'd0,1);
      tbl[5]  = vrow(idle,                                                   3'b000,0,1,3'd5,1);
      tbl[6]  = vrow(idle,                                                   3'b000,0,0,3'd0,1);
      tbl[7]  = vrow(st(0,1,0,0,1, 8'h40,6'd5,3'd2, 8'h0,6'd0,3'd0),         3'b010,0,0,3'd0,1);
      tbl[8]  = vrow(st(0,0,1,0,1, 8'h0,6'd0,3'd0, 8'h40,6'd5,3'd4),         3'b001,1,1,3'd2,1);
      tbl[9]  = vrow(idle,                                                   3'b000,0,0,3'd0,1);
      tbl[10] = vrow(st(0,0,1,0,1, 8'h0,6'd0,3'd0, 8'h41,6'd5,3'd4),         3'b001,0,0,3'd0,1);
      tbl[11] = vrow(st(0,0,0,0,0, 8'h0,6'd0,3'd0, 8'h0,6'd0,3'd0),          3'b000,0,1,3'd4,1);
      tbl[12] = vrow(st(0,0,0,1,0, 8'h0,6'd0,3'd0, 8'h0,6'd0,3'd0),          3'b000,0,1,3'd4,1);
      tbl[13] = vrow(st(0,0,1,0,0, 8'h0,6'd0,3'd0, 8'h40,6'd5,3'd6),         3'b001,0,0,3'd0,0);
      tbl[14] = vrow(idle,                                                   3'b000,0,1,3'd6,0);
      tbl[15] = vrow(st(0,0,1,1,1, 8'h0,6'd0,3'd0, 8'h50,6'd7,3'd1),         3'b000,0,0,3'd0,0);
      tbl[16] = vrow(idle,                                                   3'b000,0,0,3'd0,0);

      // Reset state
      drive(st(0,0,0,0,0, 8'h0,6'd0,3'd0, 8'h0,6'd0,3'd0));
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_tag_vld",  64'(bus.tag_req_vld), 64'd0);
      chk("rst_rdy",      64'({bus.snp_req_rdy, bus.up_req_rdy, bus.pf_req_rdy}), 64'd0);
      chk("rst_pf_drop",  64'(bus.pf_drop), 64'd0);
      chk("rst_promoted", 64'(bus.pf_promoted), 64'd0);
      chk("rst_age",      64'(bus.dbg_pf_age), 64'd0);
      chk("rst_last_up",  64'(bus.dbg_last_up_vld), 64'd0);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 17; i++) begin
         step(tbl[i].s, 0);
         chk($sformatf("tbl%0d_rdy", i), 64'({bus.snp_req_rdy, bus.up_req_rdy, bus.pf_req_rdy}), 64'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_drop", i), 64'(bus.pf_drop), 64'(tbl[i].e_drop));
         chk($sformatf("tbl%0d_tvld", i), 64'(bus.tag_req_vld), 64'(tbl[i].e_tvld));
         if (tbl[i].e_tvld) chk($sformatf("tbl%0d_tidx", i), 64'(bus.tag_req_index), 64'(tbl[i].e_tidx));
         chk($sformatf("tbl%0d_luv", i), 64'(bus.dbg_last_up_vld), 64'(tbl[i].e_luv));
      end

      // Starvation: upstream and prefetch held, prefetch wins on cycle LIMIT+1
      up_wins = 0;
      for (int c = 0; c < LIMIT + 2; c++) begin
         step(st(0,1,1,0,1, 8'h60,6'd8,3'd1, 8'h70,6'd9,3'd2), 0);
         if (c < LIMIT && bus.up_req_rdy) up_wins++;
         chk($sformatf("starve%0d_pf_rdy", c), 64'(bus.pf_req_rdy), 64'(c == LIMIT));
         chk($sformatf("starve%0d_up_rdy", c), 64'(bus.up_req_rdy), 64'(c != LIMIT));
         chk($sformatf("starve%0d_promoted", c), 64'(bus.pf_promoted), 64'(c == LIMIT));
         chk($sformatf("starve%0d_age", c), 64'(bus.dbg_pf_age), 64'((c <= LIMIT) ? c : 0));
      end
      chk("starve_up_wins", 64'(up_wins), 64'(LIMIT));

      // Backpressure: load an upstream, then stall 4 cycles with all sources valid
      step(st(0,1,1,0,1, 8'h21,6'd3,3'd7, 8'h22,6'd4,3'd1), 0);
      chk("bp_load_up_rdy", 64'(bus.up_req_rdy), 64'd1);
      bp_pld = mk(UPSTREAM_OPCODE, 8'h21, 6'd3, 6'd0);
      for (int c = 0; c < 4; c++) begin
         rs = st(1,1,1,0,0, 8'h23,6'd5,3'd3, 8'h24,6'd6,3'd4);
         step(rs, 0);
         chk($sformatf("bp%0d_rdy", c), 64'({bus.snp_req_rdy, bus.up_req_rdy, bus.pf_req_rdy}), 64'd0);
         chk($sformatf("bp%0d_tvld", c), 64'(bus.tag_req_vld), 64'd1);
         chk($sformatf("bp%0d_pld", c), 64'(bus.tag_req_pld), 64'(bp_pld));
         chk($sformatf("bp%0d_idx", c), 64'(bus.tag_req_index), 64'd7);
         chk($sformatf("bp%0d_age", c), 64'(bus.dbg_pf_age), 64'd2);
      end
      step(st(1,1,1,0,1, 8'h23,6'd5,3'd3, 8'h24,6'd6,3'd4), 0);
      chk("bp_release_snp_rdy", 64'(bus.snp_req_rdy), 64'd1);
      step(idle, 0);
      chk("bp_snp_out_vld", 64'(bus.tag_req_vld), 64'd1);
      chk("bp_snp_out_idx", 64'(bus.tag_req_index), 64'd0);

      // Randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         heavy      = ((i / 400) % 2) == 1;
         rs.snp     = ($urandom_range(0, 7) == 0);
         rs.up      = heavy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
         rs.pf      = ($urandom_range(0, 2) != 0);
         rs.fl      = ($urandom_range(0, 19) == 0);
         rs.trdy    = ($urandom_range(0, 3) != 0);
         rs.snp_tag = 8'($urandom_range(0, 255));
         rs.up_tag  = 8'($urandom_range(0, 3));
         rs.pf_tag  = 8'($urandom_range(0, 3));
         rs.up_line = 6'($urandom_range(0, 1));
         rs.pf_line = 6'($urandom_range(0, 1));
         rs.up_mi   = 3'($urandom_range(0, 7));
         rs.pf_mi   = 3'($urandom_range(0, 7));
         rs.off     = 6'($urandom_range(0, 63));
         step(rs, 1);
      end

      // Reset while a request is held drops it
      step(st(0,1,1,0,0, 8'h33,6'd1,3'd2, 8'h34,6'd2,3'd3), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_tag_vld", 64'(bus.tag_req_vld), 64'd0);
      chk("midrst_age", 64'(bus.dbg_pf_age), 64'd0);
      chk("midrst_last_up", 64'(bus.dbg_last_up_vld), 64'd0);
      model_reset();
      drive(st(0,0,0,0,1, 8'h0,6'd0,3'd0, 8'h0,6'd0,3'd0));
      @(negedge clk);
      rst_n = 1'b1;
      step(idle, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
